// File: rtl/cs_check.sv
`default_nettype none
// ============================================================================
//  Module   : cs_check
//  Brief    : Receive-side one's-complement checksum checker. Accepts one
//             packet holding two data fields plus their 8-bit checksums,
//             re-accumulates each field byte-serially with end-around carry
//             and reports a per-field pass flag and the final accumulators.
//  Revision : 1.0 - initial release
// ============================================================================
module cs_check #(
  parameter int WIDTH_DATA_1   = 384,
  parameter int WIDTH_RESULT_1 = 8,
  parameter int WIDTH_DATA_2   = 128,
  parameter int WIDTH_RESULT_2 = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  input  logic [WIDTH_DATA_1+WIDTH_DATA_2-1:0]   data,
  input  logic [WIDTH_RESULT_1+WIDTH_RESULT_2-1:0] result,
  output logic                                   in_ready,
  output logic                                   out_valid,
  output logic [1:0]                             pass,
  output logic [WIDTH_RESULT_1+WIDTH_RESULT_2-1:0] syndrome
);

  localparam int N1    = WIDTH_DATA_1 / 8;
  localparam int N2    = WIDTH_DATA_2 / 8;
  localparam int CNT_W = (N1 > 1) ? $clog2(N1) : 1;
  localparam int RES_W = WIDTH_RESULT_1 + WIDTH_RESULT_2;

  // Byte index of the final field-1 byte; the count stops here.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N1 - 1);
  // One extra bit so N2 == N1 (which may not fit in CNT_W) compares cleanly.
  localparam logic [CNT_W:0]   N2_CNT   = (CNT_W + 1)'(N2);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // End-around-carry add; the folded carry can never overflow again.
  function automatic logic [7:0] eac_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] t;
    t = {1'b0, a} + {1'b0, b};
    return t[7:0] + {7'b0, t[8]};
  endfunction

  logic [1:0]              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [WIDTH_DATA_1-1:0] sh1_q, sh1_d;
  logic [WIDTH_DATA_2-1:0] sh2_q, sh2_d;
  logic [7:0]              acc1_q, acc1_d;
  logic [7:0]              acc2_q, acc2_d;
  logic [1:0]              pass_q, pass_d;
  logic [RES_W-1:0]        syn_q, syn_d;
  logic [7:0]              acc1_nxt, acc2_nxt;

  // State and datapath registers; reset returns everything to idle values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh1_q   <= '0;
      sh2_q   <= '0;
      acc1_q  <= '0;
      acc2_q  <= '0;
      pass_q  <= '0;
      syn_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
      acc1_q  <= acc1_d;
      acc2_q  <= acc2_d;
      pass_q  <= pass_d;
      syn_q   <= syn_d;
    end
  end

  // Next-state logic: accept, walk every field-1 byte, then one verdict cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_ACC;
      S_ACC:   if (cnt_q == CNT_LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: load on accept, then fold the low byte of each shift register
  // per cycle; field 2 stops contributing once its N2 bytes are consumed.
  always_comb begin
    cnt_d    = cnt_q;
    sh1_d    = sh1_q;
    sh2_d    = sh2_q;
    acc1_d   = acc1_q;
    acc2_d   = acc2_q;
    pass_d   = pass_q;
    syn_d    = syn_q;
    acc1_nxt = eac_add(acc1_q, sh1_q[7:0]);
    acc2_nxt = ({1'b0, cnt_q} < N2_CNT) ? eac_add(acc2_q, sh2_q[7:0]) : acc2_q;

    if (state_q == S_IDLE && in_valid) begin
      sh1_d  = data[WIDTH_DATA_1+WIDTH_DATA_2-1:WIDTH_DATA_2];
      sh2_d  = data[WIDTH_DATA_2-1:0];
      acc1_d = result[RES_W-1 -: 8];
      acc2_d = result[7:0];
      cnt_d  = '0;
    end else if (state_q == S_ACC) begin
      acc1_d = acc1_nxt;
      acc2_d = acc2_nxt;
      sh1_d  = sh1_q >> 8;
      sh2_d  = sh2_q >> 8;
      if (cnt_q == CNT_LAST) begin
        // Verdict registers change only on the way into DONE.
        pass_d = {acc1_nxt == 8'hFF, acc2_nxt == 8'hFF};
        syn_d  = {acc1_nxt, acc2_nxt};
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Outputs decoded from the state register plus the held verdict.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    pass      = pass_q;
    syndrome  = syn_q;
  end

endmodule
`default_nettype wire

// File: doc/cs_check.md
# cs_check

Receive-side checksum checker for the CheckSum datapath. It accepts one packet carrying two data fields plus their transmitted 8-bit checksums. It re-accumulates each field byte-serially with end-around-carry (one's-complement) addition and reports a per-field pass/fail flag and syndrome. It is the consumer at the far end of the link whose producer generates the checksums.

## Interface
- WIDTH_DATA_1, 384, field-1 width in bits; multiple of 8; N1 = WIDTH_DATA_1/8 bytes
- WIDTH_RESULT_1, 8, field-1 checksum width; fixed at 8
- WIDTH_DATA_2, 128, field-2 width in bits; multiple of 8; N2 = WIDTH_DATA_2/8 bytes; N2 <= N1 required
- WIDTH_RESULT_2, 8, field-2 checksum width; fixed at 8

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  packet present on data/result
- data  in  WIDTH_DATA_1+WIDTH_DATA_2  field 1 = data[W1+W2-1:W2], field 2 = data[W2-1:0]
- result  in  16  received checksums: [15:8] field 1, [7:0] field 2
- in_ready  out  1  high only in IDLE; a packet is accepted on the edge where in_valid & in_ready
- out_valid  out  1  one-cycle verdict strobe
- pass  out  2  [1] field 1 ok, [0] field 2 ok
- syndrome  out  16  final accumulators: [15:8] field 1, [7:0] field 2

## Operation
- Checksum definition: the transmitter sends C = ~S, where S is the 8-bit end-around-carry sum of the field's bytes. A field passes iff the end-around-carry sum of all its bytes plus the received C equals 8'hFF.
- End-around add: t = a + b (9 bits); result = t[7:0] + t[8].
- Byte k of a field is bits [8k+7:8k]. Bytes are accumulated in ascending k (LSB byte first).
- FSM states: IDLE, ACC, DONE.
  - IDLE → ACC on accept. The accept edge registers both fields into shift registers, sets acc1 = result[15:8] and acc2 = result[7:0], and sets cnt = 0.
  - ACC: each cycle, acc1 ⊕= byte cnt of field 1. If cnt < N2, acc2 ⊕= byte cnt of field 2. cnt increments. After processing cnt = N1-1 (the last byte), go to DONE.
  - DONE: out_valid = 1, pass[1] = (acc1 == 8'hFF), pass[0] = (acc2 == 8'hFF), syndrome = {acc1, acc2}. Next state is IDLE.
- cnt width is clog2(N1); no wrap beyond N1-1.
- in_valid while not in IDLE is ignored; the packet is not queued and no error is raised.
- pass and syndrome are registered. They update only on entry to DONE and hold their values until the next verdict. They are meaningful only when out_valid = 1.

## Timing
- Reset values: out_valid = 0, pass = 2'b00, syndrome = 16'h0000, state = IDLE, cnt = 0, acc1 = acc2 = 0. in_ready reads 1 the cycle after rst deasserts.
- Accept at edge T. ACC occupies cycles T+1..T+N1 (48 cycles by default). out_valid is high for exactly cycle T+N1+1 (T+49).
- in_ready is low in cycles T+1..T+N1+1 and high again at T+N1+2. Minimum packet spacing is N1+2 cycles (50).
- in_valid held high continuously: a new packet is accepted on every edge where in_ready = 1.
- rst asserted in any state, including mid-ACC or DONE: the next state is IDLE and all registers take their reset values. No out_valid is produced for the aborted packet.
- rst and in_valid in the same cycle: rst wins and no accept occurs.

## Test plan
- All-zero data, result = 16'hFFFF → at T+49: out_valid = 1, pass = 2'b11, syndrome = 16'hFFFF. out_valid is 0 at T+48 and at T+50.
- Every byte 8'h01, result = {8'hCF, 8'hEF} → pass = 2'b11, syndrome = 16'hFFFF. Then the same data with result = {8'hCF, 8'hEE} → pass = 2'b10, syndrome = 16'hFFFE.
- Wrap-around: every byte 8'hFF, result = 16'h0000 → pass = 2'b11, syndrome = 16'hFFFF (exercises the carry fold on every add).
- Busy drop: accept packet A (all 8'h01, result = {8'hCF, 8'hEF}). At T+5 drive packet B with result = 16'h1234 → a single verdict at T+49 with pass = 2'b11. B is never accepted; in_ready stays 0 until T+50.
- Reset mid-packet: accept at T, assert rst at T+20 for one cycle → out_valid stays 0 through T+60. in_ready is 1 at T+22. A new valid packet accepted at T+22 yields a verdict at T+71.
- Back-to-back: in_valid held high with three correct packets → accepts at T, T+50, T+100; out_valid pulses at T+49, T+99, T+149, each with pass = 2'b11.
